// File: rtl/gshare_pkg.sv
// Shared definitions for the gshare branch predictor: counter states,
// default table sizes and the 2-bit saturating counter update.
package gshare_pkg;

  localparam int GHR_BITS_DEFAULT = 8;
  localparam int BTB_BITS_DEFAULT = 6;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_state_e;

  function automatic logic [1:0] sat_update(input logic [1:0] state, input logic taken);
    logic [1:0] result;
    result = state;
    if (taken) begin
      if (state != ST) result = state + 2'd1;
    end else begin
      if (state != SNT) result = state - 2'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/gshare_if.sv
// Fetch lookup and branch resolution signals between the pipeline and the predictor.
interface gshare_if;
  logic [31:0] pcF;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [1:0]  pred_state;
  logic        btb_hit;

  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [1:0]  upd_state;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;

  logic        mispredict;
  logic [31:0] recover_pc;
  logic [31:0] branch_count;
  logic [31:0] mispred_count;

  modport master (
    output pcF, upd_valid, upd_pc, upd_taken, upd_target, upd_state,
           upd_pred_taken, upd_pred_target,
    input  pred_taken, pred_target, pred_state, btb_hit,
           mispredict, recover_pc, branch_count, mispred_count
  );

  modport slave (
    input  pcF, upd_valid, upd_pc, upd_taken, upd_target, upd_state,
           upd_pred_taken, upd_pred_target,
    output pred_taken, pred_target, pred_state, btb_hit,
           mispredict, recover_pc, branch_count, mispred_count
  );
endinterface

// File: rtl/gshare_btb.sv
// Direct-mapped branch target buffer: valid bits clear asynchronously,
// combinational tag-compare read port and a single write port.
module gshare_btb
  import gshare_pkg::*;
#(
  parameter int BTB_BITS = BTB_BITS_DEFAULT,
  parameter int TAG_BITS = 30 - BTB_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [BTB_BITS-1:0] rd_idx,
  input  logic [TAG_BITS-1:0] rd_tag,
  output logic                rd_hit,
  output logic [31:0]         rd_target,
  input  logic                wr_en,
  input  logic [BTB_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0] wr_tag,
  input  logic [31:0]         wr_target
);

  localparam int ENTRIES = 1 << BTB_BITS;

  logic [ENTRIES-1:0]  valid_reg;
  logic [TAG_BITS-1:0] tag_mem    [ENTRIES];
  logic [31:0]         target_mem [ENTRIES];

  // Only the valid bits need clearing; stale tags/targets are masked by them.
  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_valid
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          valid_reg[gi] <= 1'b0;
        end else if (wr_en && (wr_idx == BTB_BITS'(gi))) begin
          valid_reg[gi] <= 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      tag_mem[wr_idx]    <= wr_tag;
      target_mem[wr_idx] <= wr_target;
    end
  end

  always_comb begin
    rd_hit    = valid_reg[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    rd_target = target_mem[rd_idx];
  end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor with BTB for the fetch stage; non-speculative
// history updated at branch resolution, plus misprediction detection and stats.
module gshare_predictor
  import gshare_pkg::*;
#(
  parameter int GHR_BITS = GHR_BITS_DEFAULT,
  parameter int BTB_BITS = BTB_BITS_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  gshare_if.slave bp
);

  localparam int PHT_ENTRIES = 1 << GHR_BITS;
  localparam int TAG_BITS    = 30 - BTB_BITS;

  logic [GHR_BITS-1:0] ghr_reg;
  logic [1:0]          pht_reg [PHT_ENTRIES];
  logic [31:0]         branch_count_reg;
  logic [31:0]         mispred_count_reg;

  logic [GHR_BITS-1:0] lookup_idx;
  logic [GHR_BITS-1:0] upd_idx;
  logic [1:0]          upd_state_next;
  logic                btb_hit;
  logic [31:0]         btb_target;
  logic                btb_wr_en;
  logic                mispredict;
  logic                unused_lsbs;

  assign lookup_idx     = bp.pcF[GHR_BITS+1:2] ^ ghr_reg;
  // Update index uses the history before this cycle's shift.
  assign upd_idx        = bp.upd_pc[GHR_BITS+1:2] ^ ghr_reg;
  assign upd_state_next = sat_update(bp.upd_state, bp.upd_taken);
  assign btb_wr_en      = bp.upd_valid & bp.upd_taken;
  assign unused_lsbs    = ^{bp.pcF[1:0], bp.upd_pc[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PHT_ENTRIES; i++) begin
        pht_reg[i] <= WNT;
      end
    end else if (bp.upd_valid) begin
      pht_reg[upd_idx] <= upd_state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr_reg <= '0;
    end else if (bp.upd_valid) begin
      ghr_reg <= {ghr_reg[GHR_BITS-2:0], bp.upd_taken};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_count_reg  <= '0;
      mispred_count_reg <= '0;
    end else begin
      if (bp.upd_valid) branch_count_reg  <= branch_count_reg + 32'd1;
      if (mispredict)   mispred_count_reg <= mispred_count_reg + 32'd1;
    end
  end

  gshare_btb #(
    .BTB_BITS (BTB_BITS),
    .TAG_BITS (TAG_BITS)
  ) u_btb (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (bp.pcF[BTB_BITS+1:2]),
    .rd_tag    (bp.pcF[31:BTB_BITS+2]),
    .rd_hit    (btb_hit),
    .rd_target (btb_target),
    .wr_en     (btb_wr_en),
    .wr_idx    (bp.upd_pc[BTB_BITS+1:2]),
    .wr_tag    (bp.upd_pc[31:BTB_BITS+2]),
    .wr_target (bp.upd_target)
  );

  // A taken branch predicted taken still mispredicts if the target was wrong.
  assign mispredict = bp.upd_valid &
                      ((bp.upd_taken != bp.upd_pred_taken) |
                       (bp.upd_taken & bp.upd_pred_taken &
                        (bp.upd_target != bp.upd_pred_target)));

  always_comb begin
    bp.pred_state    = pht_reg[lookup_idx];
    bp.btb_hit       = btb_hit;
    bp.pred_taken    = btb_hit & bp.pred_state[1];
    bp.pred_target   = btb_hit ? btb_target : 32'(bp.pcF + 32'd4);
    bp.mispredict    = mispredict;
    bp.recover_pc    = bp.upd_taken ? bp.upd_target : 32'(bp.upd_pc + 32'd4);
    bp.branch_count  = branch_count_reg;
    bp.mispred_count = mispred_count_reg;
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor: directed scenarios with literal
// expectations, then randomized traffic compared to a table-level model.
module tb_gshare_predictor;

  localparam int GB = 8;
  localparam int BB = 6;

  logic clk;
  logic reset;
  gshare_if bus ();

  gshare_predictor #(.GHR_BITS(GB), .BTB_BITS(BB)) dut (
    .clk   (clk),
    .reset (reset),
    .bp    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 0;

  // Reference model state
  int          pht_m  [1 << GB];
  bit          bv_m   [1 << BB];
  logic [31:0] btag_m [1 << BB];
  logic [31:0] btgt_m [1 << BB];
  int          ghr_m;
  logic [31:0] bc_m, mc_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < (1 << GB); i++) pht_m[i] = 1;
    for (int i = 0; i < (1 << BB); i++) bv_m[i] = 0;
    ghr_m = 0;
    bc_m  = 0;
    mc_m  = 0;
  endtask

  function automatic bit model_mispredict();
    if (!bus.upd_valid) return 0;
    if (bus.upd_taken != bus.upd_pred_taken) return 1;
    return bus.upd_taken && (bus.upd_target != bus.upd_pred_target);
  endfunction

  task automatic set_upd(input bit v, input logic [31:0] pc, input bit t,
                         input logic [31:0] tgt, input logic [1:0] st,
                         input bit pt, input logic [31:0] ptgt);
    bus.upd_valid       = v;
    bus.upd_pc          = pc;
    bus.upd_taken       = t;
    bus.upd_target      = tgt;
    bus.upd_state       = st;
    bus.upd_pred_taken  = pt;
    bus.upd_pred_target = ptgt;
  endtask

  // Model update on the clock edge, mirroring what the tables should hold.
  always @(posedge clk) begin
    if (!reset && bus.upd_valid) begin
      int idx, bi, cnt;
      idx = int'((bus.upd_pc >> 2) & 32'd255) ^ ghr_m;
      cnt = int'(bus.upd_state);
      if (bus.upd_taken) cnt = (cnt == 3) ? 3 : cnt + 1;
      else               cnt = (cnt == 0) ? 0 : cnt - 1;
      pht_m[idx] = cnt;
      if (bus.upd_taken) begin
        bi = int'((bus.upd_pc >> 2) & 32'd63);
        bv_m[bi]   = 1;
        btag_m[bi] = bus.upd_pc >> 8;
        btgt_m[bi] = bus.upd_target;
      end
      if (model_mispredict()) mc_m = mc_m + 1;
      bc_m  = bc_m + 1;
      ghr_m = ((ghr_m << 1) | int'(bus.upd_taken)) & 255;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (check_en) begin
      int idx, bi, st;
      bit hit;
      idx = int'((bus.pcF >> 2) & 32'd255) ^ ghr_m;
      bi  = int'((bus.pcF >> 2) & 32'd63);
      st  = pht_m[idx];
      hit = bv_m[bi] && (btag_m[bi] == (bus.pcF >> 8));
      check("pred_state", 32'(bus.pred_state), 32'(st));
      check("btb_hit", 32'(bus.btb_hit), 32'(hit));
      check("pred_taken", 32'(bus.pred_taken), 32'(hit && st >= 2));
      check("pred_target", bus.pred_target, hit ? btgt_m[bi] : bus.pcF + 32'd4);
      check("mispredict", 32'(bus.mispredict), 32'(model_mispredict()));
      if (bus.upd_valid)
        check("recover_pc", bus.recover_pc,
              bus.upd_taken ? bus.upd_target : bus.upd_pc + 32'd4);
      check("branch_count", bus.branch_count, bc_m);
      check("mispred_count", bus.mispred_count, mc_m);
    end
  end

  function automatic logic [31:0] rand_pc();
    logic [31:0] base;
    base = ($urandom_range(0, 1) == 1) ? 32'h0040_0000 : 32'h0080_0000;
    return base + 32'($urandom_range(0, 31) * 4);
  endfunction

  initial begin
    reset = 1'b1;
    bus.pcF = 32'h0;
    set_upd(0, 0, 0, 0, 0, 0, 0);
    model_reset();

    @(posedge clk); @(posedge clk); #1;
    bus.pcF = 32'h0040_0020;
    #1;
    check("rst_pred_taken", 32'(bus.pred_taken), 32'd0);
    check("rst_btb_hit", 32'(bus.btb_hit), 32'd0);
    check("rst_pred_state", 32'(bus.pred_state), 32'd1);
    check("rst_pred_target", bus.pred_target, 32'h0040_0024);
    reset = 1'b0;
    check_en = 1;

    // First taken branch, mispredicted; same-cycle lookup of index 0x08.
    @(posedge clk); #1;
    bus.pcF = 32'h0040_0020;
    set_upd(1, 32'h0040_0020, 1, 32'h0040_0100, 2'b01, 0, 32'h0);
    #1;
    check("first_mispredict", 32'(bus.mispredict), 32'd1);
    check("first_recover_pc", bus.recover_pc, 32'h0040_0100);
    check("same_cycle_old_state", 32'(bus.pred_state), 32'd1);

    @(posedge clk); #1;
    set_upd(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("first_branch_count", bus.branch_count, 32'd1);
    check("first_mispred_count", bus.mispred_count, 32'd1);
    check("first_btb_hit", 32'(bus.btb_hit), 32'd1);
    check("first_state_idx09", 32'(bus.pred_state), 32'd1);
    check("first_pred_taken", 32'(bus.pred_taken), 32'd0);
    check("first_btb_target", bus.pred_target, 32'h0040_0100);
    bus.pcF = 32'h0040_0024;   // index 0x09 ^ ghr 0x01 = 0x08
    #1;
    check("pht08_new_state", 32'(bus.pred_state), 32'd2);

    // Saturation at strong taken, correctly predicted.
    set_upd(1, 32'h0040_0060, 1, 32'h0040_0300, 2'b11, 1, 32'h0040_0300);
    #1;
    check("sat_st_mispredict", 32'(bus.mispredict), 32'd0);
    @(posedge clk); #1;
    set_upd(0, 0, 0, 0, 0, 0, 0);
    bus.pcF = 32'h0040_0068;   // 0x1A ^ 0x03 = 0x19
    #1;
    check("sat_st_state", 32'(bus.pred_state), 32'd3);

    // Not-taken at strong not-taken, correctly predicted.
    set_upd(1, 32'h0040_0040, 0, 32'h1234_5678, 2'b00, 0, 32'h0);
    #1;
    check("nt_mispredict", 32'(bus.mispredict), 32'd0);
    check("nt_recover_pc", bus.recover_pc, 32'h0040_0044);
    @(posedge clk); #1;
    set_upd(0, 0, 0, 0, 0, 0, 0);
    bus.pcF = 32'h0040_0054;   // 0x15 ^ 0x06 = 0x13
    #1;
    check("sat_snt_state", 32'(bus.pred_state), 32'd0);
    bus.pcF = 32'h0040_0040;
    #1;
    check("nt_btb_untouched", 32'(bus.btb_hit), 32'd0);
    check("nt_pred_target", bus.pred_target, 32'h0040_0044);

    // Correct direction, wrong target.
    set_upd(1, 32'h0040_0020, 1, 32'h0040_0200, 2'b10, 1, 32'h0040_0100);
    #1;
    check("tgt_mispredict", 32'(bus.mispredict), 32'd1);
    @(posedge clk); #1;
    set_upd(0, 0, 0, 0, 0, 0, 0);
    bus.pcF = 32'h0040_0020;
    #1;
    check("tgt_btb_hit", 32'(bus.btb_hit), 32'd1);
    check("tgt_rewritten", bus.pred_target, 32'h0040_0200);
    check("tgt_mispred_count", bus.mispred_count, 32'd2);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      bus.pcF = rand_pc();
      begin
        logic [31:0] upc, utgt;
        bit          t;
        upc  = rand_pc();
        utgt = rand_pc();
        t    = ($urandom_range(0, 1) == 1);
        set_upd($urandom_range(0, 3) != 0, upc, t, utgt,
                2'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1),
                ($urandom_range(0, 1) == 1) ? utgt : rand_pc());
      end
    end

    // Asynchronous reset between edges with an update pending.
    @(posedge clk); #2;
    bus.pcF = 32'h0040_0020;
    set_upd(1, 32'h0040_0080, 1, 32'h0040_0500, 2'b01, 0, 32'h0);
    reset = 1'b1;
    model_reset();
    #1;
    check("arst_btb_hit", 32'(bus.btb_hit), 32'd0);
    check("arst_pred_taken", 32'(bus.pred_taken), 32'd0);
    check("arst_pred_state", 32'(bus.pred_state), 32'd1);
    check("arst_pred_target", bus.pred_target, 32'h0040_0024);
    check("arst_branch_count", bus.branch_count, 32'd0);
    check("arst_mispred_count", bus.mispred_count, 32'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    set_upd(0, 0, 0, 0, 0, 0, 0);
    bus.pcF = 32'h0040_0080;
    #1;
    check("arst_no_write_btb", 32'(bus.btb_hit), 32'd0);
    check("arst_no_write_pht", 32'(bus.pred_state), 32'd1);
    check("arst_no_count", bus.branch_count, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
